// File: rtl/trap_controller_if.sv
// trap_controller_if: decode-side request, CSR access and PC-redirect bus of the trap controller.
interface trap_controller_if #(
    parameter int NUM_IRQ = 4
);
    logic               ecall;
    logic               ebreak;
    logic               illegalinst;
    logic [NUM_IRQ-1:0] irq;
    logic               mret;
    logic [31:0]        pc;
    logic               msrwen;
    logic [11:0]        csraddr;
    logic [4:0]         rs1addr;
    logic [31:0]        rs1data;
    logic [31:0]        csrdata;
    logic               exception;
    logic [31:0]        epcreturn;
    logic [31:0]        evect;

    modport master (
        output ecall, ebreak, illegalinst, irq, mret, pc, msrwen, csraddr, rs1addr, rs1data,
        input  csrdata, exception, epcreturn, evect
    );

    modport slave (
        input  ecall, ebreak, illegalinst, irq, mret, pc, msrwen, csraddr, rs1addr, rs1data,
        output csrdata, exception, epcreturn, evect
    );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: machine-mode exception/interrupt arbitration, machine CSRs,
// and one-cycle PC redirect towards direct or vectored trap targets.
module trap_controller #(
    parameter logic [31:0] VECTOR  = 32'h0000_0000,
    parameter int          NUM_IRQ = 4
) (
    input logic               I_clk,
    input logic               I_rst,
    trap_controller_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]         state;
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic               mcause_int;
    logic [4:0]         mcause_code;
    logic [31:0]        mepc;
    logic [31:0]        mtvec;
    logic [31:0]        mscratch;
    logic [NUM_IRQ-1:0] mie;
    logic [NUM_IRQ-1:0] mip;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] rise;
    logic [3:0]         irq_idx;
    logic [4:0]         exc_code;
    logic [31:0]        base;
    logic               idle;
    logic               exc;
    logic               irq_take;
    logic               mret_take;
    logic               wr;

    assign idle      = state == IDLE;
    assign pend      = mip & mie;
    assign rise      = bus.irq & ~irq_q;
    assign exc       = idle & (bus.ecall | bus.ebreak | bus.illegalinst);
    assign irq_take  = idle & ~exc & mstatus_mie & |pend;
    assign mret_take = idle & ~exc & ~irq_take & bus.mret;
    assign wr        = idle & ~exc & ~irq_take & ~mret_take & bus.msrwen & |bus.rs1addr;
    assign exc_code  = bus.illegalinst ? 5'd2 : bus.ebreak ? 5'd3 : 5'd11;

    // downward scan leaves the lowest pending index
    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) irq_idx = 4'(i);
    end

    // the 0x800 bit selects the read-only alias, so reads ignore it
    always_comb begin
        case (bus.csraddr[10:0])
            11'h7C0: bus.csrdata = {30'd0, mstatus_mpie, mstatus_mie};
            11'h7C1: bus.csrdata = {mcause_int, 26'd0, mcause_code};
            11'h7C2: bus.csrdata = mepc;
            11'h7C3: bus.csrdata = mtvec;
            11'h7C4: bus.csrdata = 32'(mie);
            11'h7C5: bus.csrdata = 32'(mip);
            11'h7C6: bus.csrdata = mscratch;
            default: bus.csrdata = '1;
        endcase
    end

    assign base          = {mtvec[31:2], 2'b00};
    assign bus.evect     = (mtvec[0] & mcause_int) ? base + {25'd0, mcause_code, 2'b00} : base;
    assign bus.epcreturn = mcause_int ? mepc : mepc + 32'd4;
    assign bus.exception = state == FLUSH;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state        <= IDLE;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mcause_int   <= 1'b0;
            mcause_code  <= '0;
            mepc         <= '0;
            mtvec        <= VECTOR & 32'hFFFF_FFFD;
            mscratch     <= '0;
            mie          <= '0;
            mip          <= '0;
            irq_q        <= '0;
        end else begin
            irq_q <= bus.irq;
            state <= (exc | irq_take) ? FLUSH : IDLE;
            // OR-ing the new edges last lets a set beat a same-cycle clear
            mip   <= ((wr && bus.csraddr == 12'h7C5) ? mip & ~bus.rs1data[NUM_IRQ-1:0] : mip) | rise;
            if (exc | irq_take) begin
                mcause_int   <= ~exc;
                mcause_code  <= exc ? exc_code : {1'b1, irq_idx};
                mepc         <= bus.pc;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (wr) begin
                case (bus.csraddr)
                    12'h7C0: {mstatus_mpie, mstatus_mie} <= bus.rs1data[1:0];
                    12'h7C1: {mcause_int, mcause_code}   <= {bus.rs1data[31], bus.rs1data[4:0]};
                    12'h7C2: mepc                        <= bus.rs1data;
                    12'h7C3: mtvec                       <= bus.rs1data & 32'hFFFF_FFFD;
                    12'h7C4: mie                         <= bus.rs1data[NUM_IRQ-1:0];
                    12'h7C6: mscratch                    <= bus.rs1data;
                    default: ;
                endcase
            end
        end
    end
endmodule
